// File: rtl/bank_queue_ctrl.sv
// Bank queue occupancy counter fed by two photocells, with a registered
// wait-time table lookup re-run whenever the occupancy or the teller count changes.
module bank_queue_ctrl #(
    parameter int CAP = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enter_sensor,
    input  logic       exit_sensor,
    input  logic [1:0] tellers,
    output logic [7:0] rom_addr,
    input  logic [7:0] rom_data,
    output logic [2:0] pcount,
    output logic [7:0] wtime,
    output logic       wt_valid,
    output logic       full,
    output logic       empty,
    output logic       ovf_err,
    output logic       unf_err
);
    localparam logic [2:0] CAP_CNT = 3'(CAP);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WAIT    = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;

    logic       enter_p0, enter_p1, enter_p2;
    logic       exit_p0, exit_p1, exit_p2;
    logic       enter_edge, exit_edge;
    logic [2:0] pcount_nxt, pcount_d;
    logic       ovf_nxt, unf_nxt;
    logic [1:0] tellers_q, tellers_d;
    logic [1:0] state, state_nxt;
    logic       trig;

    // Sensor stage: two synchronizer flops, third flop holds the previous level
    always_ff @(posedge clk) begin
        if (reset) begin
            enter_p0 <= 1'b0;
            enter_p1 <= 1'b0;
            enter_p2 <= 1'b0;
            exit_p0  <= 1'b0;
            exit_p1  <= 1'b0;
            exit_p2  <= 1'b0;
        end else begin
            enter_p0 <= enter_sensor;
            enter_p1 <= enter_p0;
            enter_p2 <= enter_p1;
            exit_p0  <= exit_sensor;
            exit_p1  <= exit_p0;
            exit_p2  <= exit_p1;
        end
    end

    assign enter_edge = enter_p1 & ~enter_p2;
    assign exit_edge  = exit_p1 & ~exit_p2;
    assign full       = (pcount == CAP_CNT);
    assign empty      = (pcount == 3'd0);

    always_comb begin
        pcount_nxt = pcount;
        ovf_nxt    = 1'b0;
        unf_nxt    = 1'b0;
        case ({enter_edge, exit_edge})
            2'b10: if (full) ovf_nxt = 1'b1; else pcount_nxt = pcount + 3'd1;
            2'b01: if (empty) unf_nxt = 1'b1; else pcount_nxt = pcount - 3'd1;
            // Simultaneous edges cancel except at the two limits, where only the legal one applies
            2'b11: begin
                if (empty)     pcount_nxt = 3'd1;
                else if (full) pcount_nxt = CAP_CNT - 3'd1;
            end
            default: ;
        endcase
    end

    // Count stage: occupancy, error pulses and previous values for change detection
    always_ff @(posedge clk) begin
        if (reset) begin
            pcount    <= 3'd0;
            pcount_d  <= 3'd0;
            ovf_err   <= 1'b0;
            unf_err   <= 1'b0;
            tellers_q <= 2'd0;
            tellers_d <= 2'd0;
        end else begin
            pcount    <= pcount_nxt;
            pcount_d  <= pcount;
            ovf_err   <= ovf_nxt;
            unf_err   <= unf_nxt;
            tellers_q <= tellers;
            tellers_d <= tellers_q;
        end
    end

    assign trig     = (pcount != pcount_d) || (tellers_q != tellers_d);
    assign rom_addr = {2'b00, tellers_q, 1'b0, pcount};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (trig) state_nxt = WAIT;
            WAIT:    state_nxt = trig ? WAIT : CAPTURE;
            CAPTURE: state_nxt = trig ? WAIT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Lookup stage: a trigger in WAIT or CAPTURE restarts, so a stale address is never captured
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            wtime    <= 8'd0;
            wt_valid <= 1'b0;
        end else begin
            state    <= state_nxt;
            wt_valid <= 1'b0;
            if (state == CAPTURE && !trig) begin
                wtime    <= rom_data;
                wt_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_bank_queue_ctrl.sv
// Directed bench for bank_queue_ctrl: a cycle-history model of the queue rules
// is compared against the DUT every cycle, plus hand-computed scenario checks.
module tb_bank_queue_ctrl;
    localparam int MAXC = 4096;

    logic       clk = 1'b0;
    logic       reset;
    logic       enter_sensor;
    logic       exit_sensor;
    logic [1:0] tellers;
    logic [7:0] rom_addr;
    logic [7:0] rom_data;
    logic [2:0] pcount;
    logic [7:0] wtime;
    logic       wt_valid, full, empty, ovf_err, unf_err;

    int n_cmp = 0;
    int n_bad = 0;

    bank_queue_ctrl #(.CAP(7)) dut (
        .clk(clk), .reset(reset), .enter_sensor(enter_sensor), .exit_sensor(exit_sensor),
        .tellers(tellers), .rom_addr(rom_addr), .rom_data(rom_data), .pcount(pcount),
        .wtime(wtime), .wt_valid(wt_valid), .full(full), .empty(empty),
        .ovf_err(ovf_err), .unf_err(unf_err)
    );

    always #5 clk = ~clk;

    // Wait-time table: pinned entries from the scenarios, zero for no tellers
    function automatic logic [7:0] rom_fn(input logic [7:0] a);
        int t, p;
        t = int'(a[5:4]);
        p = int'(a[2:0]);
        case (a)
            8'h13: return 8'h09;
            8'h17: return 8'h15;
            8'h22: return 8'h04;
            8'h37: return 8'h09;
            default: return (t == 0) ? 8'h00 : 8'(p * 5 + t * 17);
        endcase
    endfunction

    assign rom_data = rom_fn(rom_addr);

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model history, indexed by clock edge number
    bit rst_h [MAXC];
    bit ent_h [MAXC];
    bit ext_h [MAXC];
    bit chg_h [MAXC];
    int pc_h  [MAXC];
    int tq_h  [MAXC];

    int cyc = 0;
    int e_pc = 0, e_tq = 0, e_wt = 0;
    bit e_wv = 0, e_ovf = 0, e_unf = 0;
    bit started = 0;
    int vcnt = 0, ovf_cnt = 0, unf_cnt = 0;

    always @(posedge clk) begin
        int n, prev_pc, prev_tq;
        bit en, ex;
        // Pulse counters see the outputs of the cycle just ending
        vcnt    += int'(wt_valid);
        ovf_cnt += int'(ovf_err);
        unf_cnt += int'(unf_err);
        cyc++;
        n = cyc;
        if (n < MAXC) begin
            rst_h[n] = reset;
            ent_h[n] = !reset && enter_sensor;
            ext_h[n] = !reset && exit_sensor;
            if (reset) begin
                e_pc = 0; e_tq = 0; e_wt = 0;
                e_wv = 0; e_ovf = 0; e_unf = 0;
                chg_h[n] = 0;
                started = 1;
            end else begin
                // A level first seen high at edge k moves the count at edge k+2
                en = (n >= 3) && ent_h[n-2] && !ent_h[n-3];
                ex = (n >= 3) && ext_h[n-2] && !ext_h[n-3];
                prev_pc = e_pc;
                e_ovf = 0;
                e_unf = 0;
                if (en && ex) begin
                    if (prev_pc == 0) e_pc = 1;
                    else if (prev_pc == 7) e_pc = 6;
                end else if (en) begin
                    if (prev_pc == 7) e_ovf = 1; else e_pc = prev_pc + 1;
                end else if (ex) begin
                    if (prev_pc == 0) e_unf = 1; else e_pc = prev_pc - 1;
                end
                prev_tq = e_tq;
                e_tq = int'(tellers);
                chg_h[n] = (e_pc != prev_pc) || (e_tq != prev_tq);
                // Result appears three edges after a change with no later change or reset
                e_wv = (n >= 3) && chg_h[n-3] && !chg_h[n-2] && !chg_h[n-1]
                       && !rst_h[n-2] && !rst_h[n-1];
                if (e_wv) e_wt = int'(rom_fn({2'b00, 2'(tq_h[n-1]), 1'b0, 3'(pc_h[n-1])}));
            end
            pc_h[n] = e_pc;
            tq_h[n] = e_tq;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("pcount", int'(pcount), e_pc);
            check("full", int'(full), int'(e_pc == 7));
            check("empty", int'(empty), int'(e_pc == 0));
            check("ovf_err", int'(ovf_err), int'(e_ovf));
            check("unf_err", int'(unf_err), int'(e_unf));
            check("wt_valid", int'(wt_valid), int'(e_wv));
            check("wtime", int'(wtime), e_wt);
            check("rom_addr", int'(rom_addr), (e_tq << 4) | e_pc);
        end
    end

    task automatic pulse(input logic en, input logic ex);
        enter_sensor = en;
        exit_sensor  = ex;
        repeat (2) @(negedge clk);
        enter_sensor = 1'b0;
        exit_sensor  = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        int v0, o0, u0;
        reset = 1'b1;
        enter_sensor = 1'b0;
        exit_sensor = 1'b0;
        tellers = 2'd1;
        repeat (3) @(negedge clk);
        check("rst_pcount", int'(pcount), 0);
        check("rst_empty", int'(empty), 1);
        check("rst_full", int'(full), 0);
        check("rst_wtime", int'(wtime), 0);
        check("rst_wt_valid", int'(wt_valid), 0);

        // Three arrivals with one teller
        reset = 1'b0;
        repeat (8) @(negedge clk);
        v0 = vcnt;
        repeat (3) pulse(1'b1, 1'b0);
        repeat (6) @(negedge clk);
        check("a_pcount", int'(pcount), 3);
        check("a_rom_addr", int'(rom_addr), 'h13);
        check("a_wtime", int'(wtime), 'h09);
        check("a_pulses", vcnt - v0, 3);
        check("a_model_wtime", e_wt, 'h09);

        // Eight arrivals: the eighth overflows
        do_reset();
        o0 = ovf_cnt;
        u0 = unf_cnt;
        repeat (8) pulse(1'b1, 1'b0);
        repeat (6) @(negedge clk);
        check("b_pcount", int'(pcount), 7);
        check("b_full", int'(full), 1);
        check("b_wtime", int'(wtime), 'h15);
        check("b_ovf_pulses", ovf_cnt - o0, 1);
        check("b_model_pcount", e_pc, 7);
        pulse(1'b1, 1'b1);
        repeat (6) @(negedge clk);
        check("b_both_at_full", int'(pcount), 6);
        check("b_both_no_ovf", ovf_cnt - o0, 1);
        check("b_both_no_unf", unf_cnt - u0, 0);
        pulse(1'b1, 1'b1);
        repeat (4) @(negedge clk);
        check("b_both_mid", int'(pcount), 6);
        pulse(1'b1, 1'b0);
        repeat (6) @(negedge clk);

        // Arrival lands while the teller-change lookup is in flight
        pulse(1'b0, 1'b1);
        repeat (6) @(negedge clk);
        v0 = vcnt;
        enter_sensor = 1'b1;
        @(negedge clk);
        tellers = 2'd3;
        @(negedge clk);
        enter_sensor = 1'b0;
        repeat (10) @(negedge clk);
        check("c_pulses", vcnt - v0, 1);
        check("c_wtime", int'(wtime), 'h09);
        check("c_pcount", int'(pcount), 7);
        check("c_rom_addr", int'(rom_addr), 'h37);

        // Teller change alone at pcount=2
        tellers = 2'd1;
        do_reset();
        repeat (2) pulse(1'b1, 1'b0);
        repeat (6) @(negedge clk);
        tellers = 2'd2;
        repeat (4) @(negedge clk);
        check("d_wt_valid", int'(wt_valid), 1);
        check("d_wtime", int'(wtime), 'h04);
        check("d_rom_addr", int'(rom_addr), 'h22);
        repeat (4) @(negedge clk);

        // Underflow, then simultaneous entry+exit at empty
        do_reset();
        u0 = unf_cnt;
        o0 = ovf_cnt;
        pulse(1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check("e_unf_pulses", unf_cnt - u0, 1);
        check("e_pcount", int'(pcount), 0);
        check("e_empty", int'(empty), 1);
        pulse(1'b1, 1'b1);
        repeat (4) @(negedge clk);
        check("e_both_pcount", int'(pcount), 1);
        check("e_both_no_unf", unf_cnt - u0, 1);
        check("e_both_no_ovf", ovf_cnt - o0, 0);

        // Reset lands while the lookup is in CAPTURE
        tellers = 2'd3;
        repeat (3) @(negedge clk);
        v0 = vcnt;
        reset = 1'b1;
        @(negedge clk);
        check("f_wt_valid", int'(wt_valid), 0);
        check("f_pcount", int'(pcount), 0);
        check("f_wtime", int'(wtime), 0);
        check("f_empty", int'(empty), 1);
        check("f_rom_addr", int'(rom_addr), 0);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        check("f_no_aborted_pulse_then_one", vcnt - v0, 1);
        check("f_wtime_after", int'(wtime), 51);

        // Zero tellers still looks up and the table gives 0
        v0 = vcnt;
        tellers = 2'd0;
        repeat (8) @(negedge clk);
        check("g_pulses", vcnt - v0, 1);
        check("g_wtime", int'(wtime), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
